body_integrator: RTL

Downstream stage of the pairwise force pipeline in the naive N-body engine. It latches the current base body `body_i`, accumulates the N-1 force contributions produced by the force calculator, and performs one semi-implicit Euler step. It then presents the updated body for write-back to body RAM over a valid/ready handshake. All arithmetic is fixed-point: a saturating accumulator with a power-of-two timestep.

---
 rtl/nbody_pkg.sv | 39 +++
 rtl/force_accumulator.sv | 49 ++++
 rtl/body_integrator.sv | 119 +++++++++++
 3 files changed

// File: rtl/nbody_pkg.sv
// Shared types and fixed-point helpers for the N-body pipeline.
package nbody_pkg;

  localparam int FORCE_W = 32;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] vx;
    logic signed [15:0] vy;
    logic        [15:0] mass;
  } body_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    VEL,
    POS,
    HOLD
  } integ_state_t;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)       return 16'sh7fff;
    else if (v < -17'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // Result is {overflow, saturated sum}.
  function automatic logic [FORCE_W:0] sat_add32(input logic signed [FORCE_W-1:0] a,
                                                 input logic signed [FORCE_W-1:0] b);
    logic signed [FORCE_W:0] s;
    s = {a[FORCE_W-1], a} + {b[FORCE_W-1], b};
    if (s[FORCE_W] != s[FORCE_W-1])
      return {1'b1, s[FORCE_W] ? 32'h8000_0000 : 32'h7fff_ffff};
    else
      return {1'b0, s[FORCE_W-1:0]};
  endfunction

endpackage

// File: rtl/force_accumulator.sv
// Two saturating force accumulators with a contribution counter.
module force_accumulator
  import nbody_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic signed [FORCE_W-1:0] force_x,
  input  logic signed [FORCE_W-1:0] force_y,
  output logic signed [FORCE_W-1:0] acc_x,
  output logic signed [FORCE_W-1:0] acc_y,
  output logic                      done,
  output logic                      sat
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'((N > 1) ? N - 2 : 0);

  logic [CW-1:0]    cnt;
  logic [FORCE_W:0] nx, ny;

  always_comb begin
    nx   = sat_add32(acc_x, force_x);
    ny   = sat_add32(acc_y, force_y);
    // done marks the cycle that accepts contribution number N-1
    done = en && (cnt == LAST);
    sat  = en && (nx[FORCE_W] || ny[FORCE_W]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_x <= '0;
      acc_y <= '0;
      cnt   <= '0;
    end else if (clear) begin
      acc_x <= '0;
      acc_y <= '0;
      cnt   <= '0;
    end else if (en) begin
      acc_x <= nx[FORCE_W-1:0];
      acc_y <= ny[FORCE_W-1:0];
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/body_integrator.sv
// Accumulates N-1 force contributions for one body, then applies a
// semi-implicit Euler step and hands the result out over valid/ready.
module body_integrator
  import nbody_pkg::*;
#(
  parameter int N         = 16,
  parameter int FRAC_BITS = 8,
  parameter int DT_SHIFT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        body_load,
  input  logic [79:0] body_in,
  input  logic        force_valid,
  input  logic [31:0] force_x,
  input  logic [31:0] force_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] body_out,
  output logic        busy,
  output logic        overflow
);

  integ_state_t state;
  body_t        base, bo;
  logic signed [15:0] vxn, vyn;

  logic signed [FORCE_W-1:0] acc_x, acc_y, ax_sh, ay_sh;
  logic acc_clear, acc_en, acc_done, acc_sat;

  logic signed [33:0] vsum_x, vsum_y;
  logic signed [15:0] vx_c, vy_c, px_c, py_c;
  logic signed [16:0] psum_x, psum_y;
  logic vel_ovf, pos_ovf;

  assign body_out  = bo;
  assign acc_clear = (state == IDLE) && body_load;
  assign acc_en    = (state == ACCUM) && force_valid;

  force_accumulator #(.N(N)) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clear),
    .en      (acc_en),
    .force_x (force_x),
    .force_y (force_y),
    .acc_x   (acc_x),
    .acc_y   (acc_y),
    .done    (acc_done),
    .sat     (acc_sat)
  );

  function automatic logic signed [15:0] clip_wide(input logic signed [33:0] v);
    if (v > 34'sd32767)       return 16'sh7fff;
    else if (v < -34'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  always_comb begin
    ax_sh   = acc_x >>> (FRAC_BITS + DT_SHIFT);
    ay_sh   = acc_y >>> (FRAC_BITS + DT_SHIFT);
    // widened so a large accumulator can never wrap before clipping
    vsum_x  = 34'(ax_sh) + 34'(base.vx);
    vsum_y  = 34'(ay_sh) + 34'(base.vy);
    vx_c    = clip_wide(vsum_x);
    vy_c    = clip_wide(vsum_y);
    vel_ovf = (34'(vx_c) != vsum_x) || (34'(vy_c) != vsum_y);
    psum_x  = 17'(base.x) + 17'(vxn >>> DT_SHIFT);
    psum_y  = 17'(base.y) + 17'(vyn >>> DT_SHIFT);
    px_c    = sat16(psum_x);
    py_c    = sat16(psum_y);
    pos_ovf = (17'(px_c) != psum_x) || (17'(py_c) != psum_y);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      bo        <= '0;
      vxn       <= '0;
      vyn       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (body_load) begin
          base     <= body_t'(body_in);
          overflow <= 1'b0;
          busy     <= 1'b1;
          state    <= (N == 1) ? VEL : ACCUM;
        end
        ACCUM: begin
          if (acc_sat)  overflow <= 1'b1;
          if (acc_done) state    <= VEL;
        end
        VEL: begin
          vxn   <= vx_c;
          vyn   <= vy_c;
          if (vel_ovf) overflow <= 1'b1;
          state <= POS;
        end
        POS: begin
          bo        <= '{x: px_c, y: py_c, vx: vxn, vy: vyn, mass: base.mass};
          if (pos_ovf) overflow <= 1'b1;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
